multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Main control FSM for the sequential RV64 core. It sequences fetch, decode, execute, memory and writeback over a single shared memory port with a req/ready handshake, and drives the datapath's mux selects and write enables. It also maintains a retired-instruction counter and halts the core on an illegal opcode or a memory timeout. It sits in cpu beside reg_file, the ALU and the PC/IR registers.

Parameters:
MEM_TIMEOUT, 16, max wait cycles for mem_ready before bus error; 0 disables the timeout.
CNT_W, 64, width of instret.

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-high
opcode  input  7  IR[6:0], valid from DECODE onward
alu_zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current access this cycle
mem_req  output  1  memory access request
mem_we  output  1  store when 1, read when 0
mem_addr_sel  output  1  0 = PC (fetch), 1 = ALU result (data)
ir_write  output  1  load IR from memory read data
pc_write  output  1  update PC
pc_sel  output  1  0 = PC+4, 1 = branch target (old_pc+imm)
alu_src  output  1  0 = rs2, 1 = immediate
alu_op  output  2  00 add, 01 sub, 10 funct-decoded
reg_write  output  1  register file write enable
wb_sel  output  1  0 = ALU result, 1 = memory data
state  output  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7
halted  output  1  high in HALT
illegal  output  1  sticky: illegal opcode caused the halt
bus_error  output  1  sticky: memory timeout caused the halt
instret  output  CNT_W  retired instruction count

Behaviour:
- Reset (async, any state, mid-access included): state=FETCH, instret=0, illegal=0, bus_error=0, wait counter=0. All control outputs are 0 while reset is high. The first mem_req appears the first cycle after reset deasserts.
- Moore outputs decode from state. Exceptions: pc_write/ir_write in FETCH are gated by mem_ready; pc_write in EXEC is gated by alu_zero.
- FETCH: mem_req=1, mem_we=0, mem_addr_sel=0. On mem_ready: ir_write=1, pc_write=1, pc_sel=0, go to DECODE. Otherwise stay in FETCH.
- DECODE (1 cycle): samples opcode and registers it internally for later states.
  - 0110011 (R), 0010011 (I-ALU), 0000011 (LD), 0100011 (SD), 1100011 (BEQ): go to EXEC.
  - Any other opcode: go to HALT, set illegal=1.
- EXEC (1 cycle):
  - R: alu_src=0, alu_op=10.
  - I-ALU: alu_src=1, alu_op=10.
  - LD/SD: alu_src=1, alu_op=00.
  - BEQ: alu_src=0, alu_op=01; pc_write=alu_zero, pc_sel=1.
  - Next state: R/I to WB, LD/SD to MEM, BEQ to FETCH.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for SD. Hold all of these until mem_ready. On ready: LD goes to WB, SD goes to FETCH.
- WB (1 cycle): reg_write=1; wb_sel=1 for LD, 0 for R/I. Go to FETCH.
- Retire: instret += 1 on each transition into FETCH from EXEC, MEM or WB (never from reset). Wraps at 2^CNT_W.
- Latency with mem_ready high on first request: BEQ 3 cycles, R/I 4, SD 4, LD 5. Each wait cycle adds 1.
- Timeout: wait counter increments each cycle mem_req=1 and mem_ready=0, and clears on any state change.
  - If the counter reaches MEM_TIMEOUT while still waiting: go to HALT, bus_error=1, mem_req drops the next cycle.
  - mem_ready in the same cycle the count is reached wins; no error.
- HALT: absorbing until reset. All enables 0, halted=1, instret frozen.

Test Plan:
- Reset mid-MEM of an SD (mem_req=1, mem_we=1) -> same cycle mem_req=0, mem_we=0, state=0; instret=0.
- ADDI, then BEQ with alu_zero=1, then LD, then SD, all with mem_ready tied 1 -> states 0,1,2,4 / 0,1,2 / 0,1,2,3,4 / 0,1,2,3; BEQ shows pc_write=1, pc_sel=1 in EXEC; instret=4 after 16 cycles.
- BEQ with alu_zero=0 -> pc_write=0 in EXEC; instret still increments.
- FETCH with mem_ready low for 5 cycles (MEM_TIMEOUT=16) -> mem_req held 6 cycles; single ir_write and pc_write on the ready cycle.
- MEM_TIMEOUT=4, LD with mem_ready never asserted -> HALT after 4 wait cycles; bus_error=1, halted=1, mem_req=0; state stays 7 for 20 further cycles.
- opcode=1111111 in DECODE -> next cycle state=7, illegal=1, no reg_write or mem_req thereafter; reset clears illegal.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the sequential RV64 core: sequences fetch/decode/execute/
// memory/writeback over one shared memory port and counts retired instructions.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             wb_sel,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic             bus_error,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    C_R   = 3'd0,
    C_I   = 3'd1,
    C_LD  = 3'd2,
    C_SD  = 3'd3,
    C_BEQ = 3'd4
  } cls_e;

  localparam logic [6:0]  OP_R   = 7'b0110011;
  localparam logic [6:0]  OP_I   = 7'b0010011;
  localparam logic [6:0]  OP_LD  = 7'b0000011;
  localparam logic [6:0]  OP_SD  = 7'b0100011;
  localparam logic [6:0]  OP_BEQ = 7'b1100011;
  localparam logic [31:0] TIMEOUT_LIM = 32'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d;
  logic [31:0]      wait_q, wait_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             illegal_q, illegal_d;
  logic             bus_error_q, bus_error_d;
  logic             waiting;
  logic             timeout_hit;

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    wait_d      = wait_q;
    instret_d   = instret_q;
    illegal_d   = illegal_q;
    bus_error_d = bus_error_q;
    waiting     = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
    // The wait that would bring the count up to the limit is the one that halts.
    timeout_hit = (TIMEOUT_LIM != 32'd0) && ((wait_q + 32'd1) == TIMEOUT_LIM);

    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d     = S_HALT;
          bus_error_d = 1'b1;
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
        case (opcode)
          OP_R:    cls_d = C_R;
          OP_I:    cls_d = C_I;
          OP_LD:   cls_d = C_LD;
          OP_SD:   cls_d = C_SD;
          OP_BEQ:  cls_d = C_BEQ;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        case (cls_q)
          C_BEQ:      state_d = S_FETCH;
          C_LD, C_SD: state_d = S_MEM;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = (cls_q == C_LD) ? S_WB : S_FETCH;
        end else if (timeout_hit) begin
          state_d     = S_HALT;
          bus_error_d = 1'b1;
        end
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_HALT;
    endcase

    if ((state_d == S_FETCH) &&
        ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB))) begin
      instret_d = instret_q + CNT_W'(1);
    end

    if (state_d != state_q) begin
      wait_d = 32'd0;
    end else if (waiting) begin
      wait_d = wait_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      cls_q       <= C_R;
      wait_q      <= 32'd0;
      instret_q   <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      wait_q      <= wait_d;
      instret_q   <= instret_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
    end
  end

  // Control outputs decode from the state register; reset forces them low at once.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_sel       = 1'b0;
    alu_src      = 1'b0;
    alu_op       = 2'b00;
    reg_write    = 1'b0;
    wb_sel       = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_EXEC: begin
          case (cls_q)
            C_R:        alu_op = 2'b10;
            C_I:        begin alu_src = 1'b1; alu_op = 2'b10; end
            C_LD, C_SD: alu_src = 1'b1;
            C_BEQ:      begin alu_op = 2'b01; pc_sel = 1'b1; pc_write = alu_zero; end
            default:    alu_op = 2'b00;
          endcase
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (cls_q == C_SD);
        end
        S_WB: begin
          reg_write = 1'b1;
          wb_sel    = (cls_q == C_LD);
        end
        default: ;
      endcase
    end
  end

  assign state     = state_q;
  assign halted    = (state_q == S_HALT);
  assign illegal   = illegal_q;
  assign bus_error = bus_error_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: two instances (timeout 16 and 4) driven in lockstep
// and compared every cycle against an instruction-sequence model.
module tb_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic       alu_zero;
  logic       mem_ready;

  logic mem_req0, mem_we0, mem_addr_sel0, ir_write0, pc_write0, pc_sel0, alu_src0;
  logic reg_write0, wb_sel0, halted0, illegal0, bus_error0;
  logic [1:0] alu_op0;
  logic [2:0] st0;
  logic [63:0] instret0;
  logic mem_req1, mem_we1, mem_addr_sel1, ir_write1, pc_write1, pc_sel1, alu_src1;
  logic reg_write1, wb_sel1, halted1, illegal1, bus_error1;
  logic [1:0] alu_op1;
  logic [2:0] st1;
  logic [63:0] instret1;

  multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(64)) dut0 (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(mem_req0), .mem_we(mem_we0), .mem_addr_sel(mem_addr_sel0), .ir_write(ir_write0),
    .pc_write(pc_write0), .pc_sel(pc_sel0), .alu_src(alu_src0), .alu_op(alu_op0),
    .reg_write(reg_write0), .wb_sel(wb_sel0), .state(st0), .halted(halted0),
    .illegal(illegal0), .bus_error(bus_error0), .instret(instret0));

  multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(64)) dut1 (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr_sel(mem_addr_sel1), .ir_write(ir_write1),
    .pc_write(pc_write1), .pc_sel(pc_sel1), .alu_src(alu_src1), .alu_op(alu_op1),
    .reg_write(reg_write1), .wb_sel(wb_sel1), .state(st1), .halted(halted1),
    .illegal(illegal1), .bus_error(bus_error1), .instret(instret1));

  logic [13:0] ctl0, ctl1;
  assign ctl0 = {mem_req0, mem_we0, mem_addr_sel0, ir_write0, pc_write0, pc_sel0, alu_src0,
                 alu_op0, reg_write0, wb_sel0, halted0, illegal0, bus_error0};
  assign ctl1 = {mem_req1, mem_we1, mem_addr_sel1, ir_write1, pc_write1, pc_sel1, alu_src1,
                 alu_op1, reg_write1, wb_sel1, halted1, illegal1, bus_error1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: each instruction is a fetch, a decode, then a list of phases chosen by opcode.
  int          ph  [2];
  int          sq  [2][4];
  int          n   [2];
  int          pos [2];
  int          wt  [2];
  bit          ill [2];
  bit          be  [2];
  logic [6:0]  opc [2];
  logic [63:0] cnt [2];
  int          tmo [2];

  task automatic chk(input string name, input int m, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", name, m, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      ph[m] = 0; n[m] = 0; pos[m] = 0; wt[m] = 0;
      ill[m] = 0; be[m] = 0; cnt[m] = '0; opc[m] = '0;
    end
  endtask

  function automatic logic [13:0] exp_ctl(input int m);
    logic mreq, we, as, irw, pcw, pcs, asrc, rw, wbs;
    logic [1:0] aop;
    mreq = 0; we = 0; as = 0; irw = 0; pcw = 0; pcs = 0; asrc = 0; rw = 0; wbs = 0; aop = 2'b00;
    if (!reset) begin
      case (ph[m])
        0: begin mreq = 1; irw = mem_ready; pcw = mem_ready; end
        2: begin
          asrc = (opc[m] != 7'h33) && (opc[m] != 7'h63);
          aop  = (opc[m] == 7'h33 || opc[m] == 7'h13) ? 2'b10 : (opc[m] == 7'h63 ? 2'b01 : 2'b00);
          pcs  = (opc[m] == 7'h63);
          pcw  = (opc[m] == 7'h63) && alu_zero;
        end
        3: begin mreq = 1; as = 1; we = (opc[m] == 7'h23); end
        4: begin rw = 1; wbs = (opc[m] == 7'h03); end
        default: ;
      endcase
    end
    return {mreq, we, as, irw, pcw, pcs, asrc, aop, rw, wbs, (ph[m] == 7), ill[m], be[m]};
  endfunction

  task automatic wait_tick(input int m);
    wt[m]++;
    if (tmo[m] != 0 && wt[m] == tmo[m]) begin
      ph[m] = 7; be[m] = 1; wt[m] = 0;
    end
  endtask

  task automatic advance(input int m);
    pos[m]++;
    wt[m] = 0;
    if (pos[m] == n[m]) begin
      ph[m] = 0;
      cnt[m] = cnt[m] + 64'd1;
    end else begin
      ph[m] = sq[m][pos[m]];
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      case (ph[m])
        0: if (mem_ready) begin ph[m] = 1; wt[m] = 0; end else wait_tick(m);
        1: begin
          opc[m] = opcode;
          case (opcode)
            7'h33, 7'h13: begin sq[m][0] = 2; sq[m][1] = 4; n[m] = 2; end
            7'h03:        begin sq[m][0] = 2; sq[m][1] = 3; sq[m][2] = 4; n[m] = 3; end
            7'h23:        begin sq[m][0] = 2; sq[m][1] = 3; n[m] = 2; end
            7'h63:        begin sq[m][0] = 2; n[m] = 1; end
            default:      n[m] = 0;
          endcase
          pos[m] = 0;
          if (n[m] == 0) begin ph[m] = 7; ill[m] = 1; end
          else ph[m] = sq[m][0];
        end
        2, 4: advance(m);
        3: if (mem_ready) advance(m); else wait_tick(m);
        default: ;
      endcase
    end
  endtask

  task automatic compare();
    chk("ctl",     0, 64'(ctl0), 64'(exp_ctl(0)));
    chk("state",   0, 64'(st0),  64'(ph[0]));
    chk("instret", 0, instret0,  cnt[0]);
    chk("ctl",     1, 64'(ctl1), 64'(exp_ctl(1)));
    chk("state",   1, 64'(st1),  64'(ph[1]));
    chk("instret", 1, instret1,  cnt[1]);
  endtask

  task automatic drive(input logic r, input logic [6:0] op, input logic z, input logic rdy);
    reset = r; opcode = op; alu_zero = z; mem_ready = rdy;
    if (r) model_reset();
    #2;
    compare();
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_step();
    #1;
  endtask

  task automatic cyc(input logic r, input logic [6:0] op, input logic z, input logic rdy);
    drive(r, op, z, rdy);
    tick();
  endtask

  task automatic run(input logic [6:0] op, input logic z, input logic rdy, input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, op, z, rdy);
  endtask

  int reqs, irws, pcws;

  initial begin
    tmo[0] = 16; tmo[1] = 4;
    reset = 1'b1; opcode = '0; alu_zero = 1'b0; mem_ready = 1'b0;
    model_reset();
    #1;
    cyc(1'b1, 7'h00, 1'b0, 1'b1);
    drive(1'b1, 7'h00, 1'b0, 1'b1);
    chk("reset_state", 0, 64'(st0), 64'd0);
    chk("reset_req",   0, 64'(mem_req0), 64'd0);
    tick();

    // ADDI, BEQ taken, LD, SD back to back with memory always ready
    run(7'h13, 1'b1, 1'b1, 4);
    run(7'h63, 1'b1, 1'b1, 2);
    drive(1'b0, 7'h63, 1'b1, 1'b1);
    chk("beq_exec_state", 0, 64'(st0), 64'd2);
    chk("beq_taken_pcw",  0, 64'(pc_write0), 64'd1);
    chk("beq_taken_psel", 0, 64'(pc_sel0), 64'd1);
    tick();
    run(7'h03, 1'b0, 1'b1, 5);
    run(7'h23, 1'b0, 1'b1, 4);
    drive(1'b0, 7'h13, 1'b0, 1'b1);
    chk("instret_after_16", 0, instret0, 64'd4);
    chk("instret_after_16", 1, instret1, 64'd4);
    tick();

    // BEQ not taken still retires (the fetch above already started it)
    run(7'h63, 1'b0, 1'b1, 1);
    drive(1'b0, 7'h63, 1'b0, 1'b1);
    chk("beq_nt_pcw", 0, 64'(pc_write0), 64'd0);
    tick();
    drive(1'b0, 7'h13, 1'b0, 1'b0);
    chk("beq_nt_instret", 0, instret0, 64'd5);
    tick();

    // Reset in the middle of an SD memory access
    cyc(1'b1, 7'h23, 1'b0, 1'b1);
    run(7'h23, 1'b0, 1'b1, 3);
    drive(1'b0, 7'h23, 1'b0, 1'b0);
    chk("sd_mem_req", 0, 64'(mem_req0), 64'd1);
    chk("sd_mem_we",  0, 64'(mem_we0), 64'd1);
    tick();
    drive(1'b1, 7'h23, 1'b0, 1'b0);
    chk("rst_mid_req",     0, 64'(mem_req0), 64'd0);
    chk("rst_mid_we",      0, 64'(mem_we0), 64'd0);
    chk("rst_mid_state",   0, 64'(st0), 64'd0);
    chk("rst_mid_instret", 0, instret0, 64'd0);
    tick();

    // LD whose data access never completes
    run(7'h03, 1'b0, 1'b1, 3);
    run(7'h03, 1'b0, 1'b0, 4);
    drive(1'b0, 7'h03, 1'b0, 1'b0);
    chk("to_halt_state", 1, 64'(st1), 64'd7);
    chk("to_bus_error",  1, 64'(bus_error1), 64'd1);
    chk("to_halted",     1, 64'(halted1), 64'd1);
    chk("to_mem_req",    1, 64'(mem_req1), 64'd0);
    chk("to_still_mem",  0, 64'(st0), 64'd3);
    tick();
    run(7'h03, 1'b0, 1'b0, 20);
    drive(1'b0, 7'h03, 1'b0, 1'b1);
    chk("to_absorbing", 1, 64'(st1), 64'd7);
    chk("to_t16_halt",  0, 64'(st0), 64'd7);
    tick();

    // Fetch stalled 5 cycles: only the 16-cycle instance survives
    cyc(1'b1, 7'h13, 1'b0, 1'b0);
    reqs = 0; irws = 0; pcws = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 7'h13, 1'b0, (i == 5));
      reqs += int'(mem_req0); irws += int'(ir_write0); pcws += int'(pc_write0);
      tick();
    end
    chk("fetch_wait_reqs", 0, 64'(reqs), 64'd6);
    chk("fetch_wait_irw",  0, 64'(irws), 64'd1);
    chk("fetch_wait_pcw",  0, 64'(pcws), 64'd1);
    run(7'h13, 1'b0, 1'b1, 3);

    // Ready arriving on the last allowed wait cycle beats the timeout
    cyc(1'b1, 7'h13, 1'b0, 1'b0);
    run(7'h13, 1'b0, 1'b0, 3);
    run(7'h13, 1'b0, 1'b1, 1);
    drive(1'b0, 7'h13, 1'b0, 1'b1);
    chk("race_state",     1, 64'(st1), 64'd1);
    chk("race_bus_error", 1, 64'(bus_error1), 64'd0);
    tick();
    run(7'h13, 1'b0, 1'b1, 3);

    // Illegal opcode halts and stays halted until reset
    cyc(1'b1, 7'h7f, 1'b0, 1'b1);
    run(7'h7f, 1'b0, 1'b1, 2);
    drive(1'b0, 7'h7f, 1'b0, 1'b1);
    chk("ill_state",   0, 64'(st0), 64'd7);
    chk("ill_flag",    0, 64'(illegal0), 64'd1);
    tick();
    run(7'h7f, 1'b0, 1'b1, 5);
    drive(1'b1, 7'h7f, 1'b0, 1'b1);
    chk("ill_cleared", 0, 64'(illegal0), 64'd0);
    tick();
    run(7'h13, 1'b0, 1'b1, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
